// File: rtl/rtc_bus_arbiter.sv
// Shares the RTC transaction engine between scan (0), user write (1) and IRQ service (2).
// Optional FRW watchdog with sticky Err is enabled by defining ARB_TIMEOUT_EN.
module rtc_bus_arbiter #(
    parameter int unsigned ACC_PULSE  = 8,
    parameter int unsigned GAP        = 2,
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [2:0] Req,
    input  logic [2:0] Wr,
    input  logic [7:0] Dir0,
    input  logic [7:0] Dir1,
    input  logic [7:0] Dir2,
    input  logic [7:0] Dato_W0,
    input  logic [7:0] Dato_W1,
    input  logic [7:0] Dato_W2,
    input  logic [7:0] Dato_in,
    input  logic       FRW,
    output logic       Acceso,
    output logic       RW,
    output logic [7:0] Dir,
    output logic [7:0] Dato_out,
    output logic [2:0] Gnt,
    output logic [2:0] Done,
    output logic [7:0] Dato_R,
    output logic       Busy,
    output logic       Err
);

    typedef enum logic [1:0] {StIdle, StXfer, StDone, StGap} state_e;

    localparam int unsigned StW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

    state_e         state_q, state_d;
    logic [2:0]     gnt_q;
    logic [2:0]     win_oh;
    logic [3:0]     acc_cnt_q;
    logic [2:0]     gap_cnt_q;
    logic [StW-1:0] starve_q;
    logic           starve_hit;
    logic           timeout;
    logic           grant;

    assign starve_hit = (starve_q == StW'(STARVE_MAX));
    assign grant      = (state_q == StIdle) && (Req != 3'b000);

    // Starved scan requester overrides the fixed 2 > 1 > 0 order.
    always_comb begin
        win_oh = 3'b000;
        if (Req[0] && starve_hit) win_oh = 3'b001;
        else if (Req[2])          win_oh = 3'b100;
        else if (Req[1])          win_oh = 3'b010;
        else if (Req[0])          win_oh = 3'b001;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state_q <= StIdle;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: if (Req != 3'b000) state_d = StXfer;
            StXfer: if (FRW || timeout) state_d = StDone;
            StDone: state_d = (GAP == 0) ? StIdle : StGap;
            StGap:  if (gap_cnt_q == 3'd1) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        Gnt    = (state_q == StXfer) ? gnt_q : 3'b000;
        Done   = (state_q == StDone) ? gnt_q : 3'b000;
        Acceso = (state_q == StXfer) && (acc_cnt_q != 4'(ACC_PULSE));
        Busy   = (state_q != StIdle);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            gnt_q     <= 3'b000;
            Dir       <= 8'h00;
            RW        <= 1'b0;
            Dato_out  <= 8'h00;
            Dato_R    <= 8'h00;
            acc_cnt_q <= 4'd0;
            gap_cnt_q <= 3'd0;
            starve_q  <= '0;
        end else begin
            if (grant) begin
                gnt_q     <= win_oh;
                acc_cnt_q <= 4'd0;
                unique case (win_oh)
                    3'b100: begin
                        Dir      <= Dir2;
                        RW       <= Wr[2];
                        Dato_out <= Dato_W2;
                    end
                    3'b010: begin
                        Dir      <= Dir1;
                        RW       <= Wr[1];
                        Dato_out <= Dato_W1;
                    end
                    default: begin
                        Dir      <= Dir0;
                        RW       <= Wr[0];
                        Dato_out <= Dato_W0;
                    end
                endcase
                if (win_oh[0] || !Req[0]) starve_q <= '0;
                else if (!starve_hit)     starve_q <= starve_q + 1'b1;
            end else if (!Req[0]) begin
                starve_q <= '0;
            end

            if (state_q == StXfer) begin
                if (acc_cnt_q != 4'(ACC_PULSE)) acc_cnt_q <= acc_cnt_q + 4'd1;
                if (FRW && !RW) Dato_R <= Dato_in;
            end

            if (state_q == StDone)     gap_cnt_q <= 3'(GAP);
            else if (state_q == StGap) gap_cnt_q <= gap_cnt_q - 3'd1;
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned ToW = $clog2(TIMEOUT + 1);

    logic [ToW-1:0] wait_cnt_q;

    assign timeout = (state_q == StXfer) && (wait_cnt_q == ToW'(TIMEOUT - 1));

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wait_cnt_q <= '0;
            Err        <= 1'b0;
        end else begin
            if (state_q == StXfer) wait_cnt_q <= wait_cnt_q + 1'b1;
            else                   wait_cnt_q <= '0;
            if (timeout && !FRW) Err <= 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
    assign Err     = 1'b0;
`endif

endmodule
